// File: rtl/uart_echo_tx.sv
// rtl/uart_echo_tx.sv - UART echo path: captures receiver bytes into a FIFO and re-sends them as 8N1 frames.
// Optional build macro ECHO_UPPERCASE_EN folds lowercase ASCII to uppercase before queuing.
module uart_echo_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] RX_DATA,
    input  logic       rx_complete_flag,
    output logic       rx_complete_del_flag,
    output logic       TXD,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       overrun_flag
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);

    typedef enum logic {CAP_IDLE, CAP_ACK} cap_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    cap_state_t        r_cap_state, w_cap_next;
    tx_state_t         r_tx_state, w_tx_next;
    logic              r_del;
    logic              w_push, w_pop, w_wr_en, w_empty, w_full;
    logic [7:0]        w_push_data;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    logic              r_overrun;
    logic [BIT_W-1:0]  r_cnt, w_cnt_next;
    logic [2:0]        r_bit, w_bit_next;
    logic [7:0]        r_shift, w_shift_next;
    logic              r_txd, w_txd_next;
    logic              r_busy, w_busy_next;

`ifdef ECHO_UPPERCASE_EN
    always_comb begin
        w_push_data = RX_DATA;
        if (RX_DATA >= 8'h61 && RX_DATA <= 8'h7A)
            w_push_data = RX_DATA & 8'hDF;
    end
`else
    assign w_push_data = RX_DATA;
`endif

    // One push per flag assertion: the ACK state swallows the rest of the held level.
    always_comb begin
        w_cap_next = r_cap_state;
        w_push     = 1'b0;
        case (r_cap_state)
            CAP_IDLE: begin
                if (rx_complete_flag) begin
                    w_push     = 1'b1;
                    w_cap_next = CAP_ACK;
                end
            end
            CAP_ACK: begin
                if (!rx_complete_flag)
                    w_cap_next = CAP_IDLE;
            end
            default: w_cap_next = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_state <= CAP_IDLE;
            r_del       <= 1'b0;
        end else begin
            r_cap_state <= w_cap_next;
            r_del       <= (w_cap_next == CAP_ACK);
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop)
                r_overrun <= 1'b1;
        end
    end

    always_comb begin
        w_tx_next    = r_tx_state;
        w_pop        = 1'b0;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        case (r_tx_state)
            T_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_bit_next   = 3'd0;
                    w_cnt_next   = BIT_LAST;
                    w_tx_next    = T_START;
                end
            end
            T_START: begin
                if (r_cnt == '0) begin
                    w_cnt_next = BIT_LAST;
                    w_tx_next  = T_DATA;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            T_DATA: begin
                if (r_cnt == '0) begin
                    w_cnt_next   = BIT_LAST;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 1'b1;
                    if (r_bit == 3'd7)
                        w_tx_next = T_STOP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            T_STOP: begin
                if (r_cnt == '0)
                    w_tx_next = T_IDLE;
                else
                    w_cnt_next = r_cnt - 1'b1;
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    // Line outputs are registered from the current state, so TXD lags the state by one cycle.
    always_comb begin
        w_txd_next  = 1'b1;
        w_busy_next = (r_tx_state != T_IDLE);
        case (r_tx_state)
            T_START: w_txd_next = 1'b0;
            T_DATA:  w_txd_next = r_shift[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= T_IDLE;
            r_cnt      <= '0;
            r_bit      <= 3'd0;
            r_shift    <= 8'h00;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_busy     <= w_busy_next;
        end
    end

    assign rx_complete_del_flag = r_del;
    assign TXD                  = r_txd;
    assign tx_busy              = r_busy;
    assign fifo_full            = w_full;
    assign overrun_flag         = r_overrun;

endmodule
